// File: rtl/out_channel_checker.sv
// Buffers a test program's "out" words in a FIFO, drains them over valid/ready and checks
// each drained word against a preloaded table. Define OUT_FIRST_MISMATCH_EN to capture the first mismatch.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 8,
  parameter int NExpect = 4,
  localparam int AW = (NExpect > 1) ? $clog2(NExpect) : 1,
  localparam int WCW = $clog2(NOut * NExpect + 1) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          exp_we,
  input  logic [AW-1:0]                 exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          wr_en,
  input  logic [MemoryElementWidth-1:0] wr_data,
  input  logic                          prog_done,
  output logic                          m_valid,
  output logic [MemoryElementWidth-1:0] m_data,
  input  logic                          m_ready,
  output logic                          finished,
  output logic                          success,
  output logic                          overflow,
  output logic [WCW-1:0]                word_count,
`ifdef OUT_FIRST_MISMATCH_EN
  output logic [WCW-1:0]                mismatch_index,
  output logic [MemoryElementWidth-1:0] mismatch_data,
`endif
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(NOut) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WCW-1:0] NEXP_W = WCW'(NExpect);

  logic [1:0]                    state;
  logic [PW-1:0]                 wr_ptr;
  logic [PW-1:0]                 rd_ptr;
  logic [MemoryElementWidth-1:0] mem [NOut];
  logic [MemoryElementWidth-1:0] exp_mem [NExpect];
  logic [MemoryElementWidth-1:0] exp_word;
  logic                          done_latch;
  logic                          mismatch;
  logic                          empty;
  logic                          full;
  logic                          pop;
  logic                          push;
  logic                          drop;
  logic                          pop_bad;

  assign dbg_state = state;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  // Drain handshake: a word transfers on every rising edge where m_valid && m_ready;
  // m_data is the registered FIFO head and holds while m_valid && !m_ready.
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr[PW-2:0]];

  assign pop  = (state == S_RUN) && m_valid && m_ready;
  assign push = (state == S_RUN) && wr_en && (!full || pop);
  assign drop = (state == S_RUN) && wr_en && full && !pop;

  always_comb begin
    exp_word = '0;
    for (int i = 0; i < NExpect; i++) begin
      if (word_count == WCW'(i)) exp_word = exp_mem[i];
    end
  end

  // Words beyond the table length always count as mismatches.
  assign pop_bad = (word_count >= NEXP_W) || (m_data != exp_word);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PW-2:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (exp_we && (state != S_RUN)) begin
      for (int i = 0; i < NExpect; i++) begin
        if (exp_addr == AW'(i)) exp_mem[i] <= exp_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_latch <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
      mismatch   <= 1'b0;
      finished   <= 1'b0;
      success    <= 1'b0;
`ifdef OUT_FIRST_MISMATCH_EN
      mismatch_index <= '0;
      mismatch_data  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done_latch <= prog_done;
            word_count <= '0;
            overflow   <= 1'b0;
            mismatch   <= 1'b0;
            finished   <= 1'b0;
            success    <= 1'b0;
`ifdef OUT_FIRST_MISMATCH_EN
            mismatch_index <= '0;
            mismatch_data  <= '0;
`endif
          end
        end
        S_RUN: begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (drop) overflow <= 1'b1;
          if (prog_done) done_latch <= 1'b1;
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (word_count != {WCW{1'b1}}) word_count <= word_count + 1'b1;
            if (pop_bad) begin
              mismatch <= 1'b1;
`ifdef OUT_FIRST_MISMATCH_EN
              if (!mismatch) begin
                mismatch_index <= word_count;
                mismatch_data  <= m_data;
              end
`endif
            end
          end
          // No pop or push can happen here (FIFO empty, no wr_en), so the flags are final.
          if (done_latch && empty && !wr_en) begin
            state    <= S_DONE;
            finished <= 1'b1;
            success  <= !mismatch && (word_count == NEXP_W) && !overflow;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
